// File: rtl/lsu_if.sv
// Execute-request, memory-bus and writeback signals of the load/store unit.
// The master modport is the LSU side; slave is the surrounding pipeline and memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;

    modport master (
        input  req_valid, req_opcode, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output resp_valid, resp_data, resp_fault
    );

    modport slave (
        output req_valid, req_opcode, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  resp_valid, resp_data, resp_fault
    );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> (WAIT) -> RESP, word-aligned bus.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned h/w accesses instead of aligning them.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic   clk,
    input logic   rst_n,
    lsu_if.master bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_FSW   = 7'b0100111;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    function automatic logic [1:0] acc_size(input logic [6:0] op, input logic [2:0] f3);
        logic [1:0] s;
        case (f3[1:0])
            2'b00:   s = SZ_B;
            2'b01:   s = SZ_H;
            default: s = SZ_W;
        endcase
        if (op == OP_FLW || op == OP_FSW) s = SZ_W;
        return s;
    endfunction

    // Byte offset inside the word after natural alignment of the access.
    function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
        logic [1:0] o;
        case (size)
            SZ_B:    o = a;
            SZ_H:    o = {a[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        case (size)
            SZ_B:    s = 4'b0001 << off;
            SZ_H:    s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic sext,
                                            input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_B:    r = {{24{sext & sh[7]}}, sh[7:0]};
            SZ_H:    r = {{16{sext & sh[15]}}, sh[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    logic       accept;
    logic       op_legal;
    logic       op_store;
    logic       trap;
    logic [1:0] in_size;
    logic [1:0] in_off;

    assign accept   = bus.req_valid && bus.req_ready;
    assign op_legal = (bus.req_opcode == OP_LOAD) || (bus.req_opcode == OP_STORE) ||
                      (bus.req_opcode == OP_FLW)  || (bus.req_opcode == OP_FSW);
    assign op_store = (bus.req_opcode == OP_STORE) || (bus.req_opcode == OP_FSW);
    assign in_size  = acc_size(bus.req_opcode, bus.req_funct3);
    assign in_off   = lane_off(in_size, bus.req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            SZ_H:    m = a[0];
            SZ_W:    m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign trap = misaligned(in_size, bus.req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Request attributes needed after the bus handshake; pure data, no reset.
    logic       r_store;
    logic       r_sext;
    logic [1:0] r_size;
    logic [1:0] r_off;

    always_ff @(posedge clk) begin
        if (accept) begin
            r_store <= op_store;
            r_sext  <= ~bus.req_funct3[2];
            r_size  <= in_size;
            r_off   <= in_off;
        end
    end

    state_t     state;
    logic [7:0] cnt;
    logic [1:0] gap;

    // gap holds req_ready low so accepts are spaced at least four cycles apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            gap            <= 2'd0;
            bus.req_ready  <= 1'b1;
            bus.mem_valid  <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= 32'd0;
            bus.mem_wdata  <= 32'd0;
            bus.mem_wstrb  <= 4'd0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= 32'd0;
            bus.resp_fault <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            if (gap != 2'd0) gap <= gap - 2'd1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        gap           <= 2'd3;
                        bus.req_ready <= 1'b0;
                        if (!op_legal || trap) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b1;
                            bus.resp_data  <= 32'd0;
                        end else begin
                            state         <= REQ;
                            bus.mem_valid <= 1'b1;
                            bus.mem_we    <= op_store;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_wdata <= op_store ? replicate(in_size, bus.req_wdata) : 32'd0;
                            bus.mem_wstrb <= op_store ? strobe(in_size, in_off) : 4'd0;
                        end
                    end else if (gap <= 2'd1) begin
                        bus.req_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_wstrb <= 4'd0;
                        if (r_store) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b0;
                            bus.resp_data  <= 32'd0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 8'd0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        state          <= RESP;
                        cnt            <= 8'd0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_fault <= 1'b0;
                        bus.resp_data  <= extract(r_size, r_sext, r_off, bus.mem_rdata);
                    end else if (cnt == CNT_LAST) begin
                        state          <= RESP;
                        cnt            <= 8'd0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_fault <= 1'b1;
                        bus.resp_data  <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.resp_fault <= 1'b0;
                    bus.resp_data  <= 32'd0;
                    bus.req_ready  <= (gap <= 2'd1);
                end
            endcase
        end
    end
endmodule
